// File: rtl/beam_pkg.sv
// Shared definitions for the beam datapath blocks (burst framer and mux).
package beam_pkg;

  // Default sample width and config-field width used by the beam blocks.
  localparam int unsigned DEFAULT_DWIDTH = 32;
  localparam int unsigned DEFAULT_LWIDTH = 16;

  // Framer control states: waiting for enable, passing a burst, idling between bursts.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } FRAMER_STATE;

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry AXI-Stream register slice carrying data, valid and last.
// One cycle of latency and full throughput: it accepts a new beat in the same
// cycle the held beat leaves.
module axis_reg_slice #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] s_tdata_i,
  input  logic              s_tvalid_i,
  input  logic              s_tlast_i,
  output logic              s_tready_o,
  output logic [DWIDTH-1:0] m_tdata_o,
  output logic              m_tvalid_o,
  output logic              m_tlast_o,
  input  logic              m_tready_i
);

  logic [DWIDTH-1:0] data_q;
  logic              valid_q;
  logic              last_q;

  assign s_tready_o = !valid_q || m_tready_i;
  assign m_tdata_o  = data_q;
  assign m_tvalid_o = valid_q;
  assign m_tlast_o  = last_q;

  // Load a new beat when there is room, drop the held beat once it has been taken,
  // and otherwise hold everything stable while the sink stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (s_tvalid_i && s_tready_o) begin
      data_q  <= s_tdata_i;
      valid_q <= 1'b1;
      last_q  <= s_tlast_i;
    end else if (valid_q && m_tready_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

endmodule

// File: rtl/beam_burst_framer.sv
// Cuts a continuous sample stream into fixed-length AXIS bursts terminated by
// tlast, with a programmable number of idle cycles between bursts so the
// downstream mux can switch DAC on each burst boundary.
module beam_burst_framer
  import beam_pkg::*;
#(
  parameter int DWIDTH = DEFAULT_DWIDTH,
  parameter int LWIDTH = DEFAULT_LWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_enable,
  input  logic [LWIDTH-1:0] cfg_burst_len,
  input  logic [LWIDTH-1:0] cfg_gap_len,
  input  logic [DWIDTH-1:0] axis_S_sample_tdata,
  input  logic              axis_S_sample_tvalid,
  output logic              axis_S_sample_tready,
  output logic [DWIDTH-1:0] axis_M_burst_tdata,
  output logic              axis_M_burst_tvalid,
  input  logic              axis_M_burst_tready,
  output logic              axis_M_burst_tlast,
  output logic              busy,
  output logic              burst_done,
  output logic [31:0]       burst_count
);

  localparam logic [LWIDTH-1:0] LEN_ONE = LWIDTH'(1);

  FRAMER_STATE       state_q;
  logic [LWIDTH-1:0] len_q;
  logic [LWIDTH-1:0] gap_q;
  logic [LWIDTH-1:0] beat_cnt_q;
  logic [LWIDTH-1:0] gap_cnt_q;
  logic [31:0]       burst_count_q;
  logic [31:0]       burst_count_d;
  logic              burst_done_q;
  logic              burst_done_d;

  logic slice_ready;
  logic beats_left;
  logic in_accept;
  logic last_beat;
  logic out_hs_last;
  logic last_gone;

  // Input is only opened while a burst still owes beats and the output stage has room.
  // Gating with rst_n keeps the source stalled during reset before the state register clears.
  assign beats_left           = (beat_cnt_q < len_q);
  assign axis_S_sample_tready = rst_n && (state_q == BURST) && beats_left && slice_ready;
  assign in_accept            = axis_S_sample_tvalid && axis_S_sample_tready;
  assign last_beat            = (beat_cnt_q == (len_q - LEN_ONE));

  // The tlast beat counts as gone in the cycle it handshakes, so the gap count
  // starts on that edge and gap_q idle GAP cycles follow the handshake.
  assign out_hs_last = axis_M_burst_tvalid && axis_M_burst_tlast && axis_M_burst_tready;
  assign last_gone   = !(axis_M_burst_tvalid && axis_M_burst_tlast) || axis_M_burst_tready;

  axis_reg_slice #(
    .DWIDTH(DWIDTH)
  ) u_out_slice (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_tdata_i (axis_S_sample_tdata),
    .s_tvalid_i(in_accept),
    .s_tlast_i (last_beat),
    .s_tready_o(slice_ready),
    .m_tdata_o (axis_M_burst_tdata),
    .m_tvalid_o(axis_M_burst_tvalid),
    .m_tlast_o (axis_M_burst_tlast),
    .m_tready_i(axis_M_burst_tready)
  );

  // Burst sequencing: config is latched only when leaving IDLE, so mid-burst
  // changes (including dropping enable) wait for the next burst start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      gap_q      <= '0;
      beat_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_enable && (cfg_burst_len != '0)) begin
            state_q    <= BURST;
            len_q      <= cfg_burst_len;
            gap_q      <= cfg_gap_len;
            beat_cnt_q <= '0;
          end
        end
        BURST: begin
          if (in_accept) begin
            beat_cnt_q <= beat_cnt_q + LEN_ONE;
            if (last_beat) begin
              state_q   <= GAP;
              gap_cnt_q <= '0;
            end
          end
        end
        GAP: begin
          if (last_gone) begin
            if (gap_cnt_q == gap_q) begin
              state_q <= IDLE;
            end else begin
              gap_cnt_q <= gap_cnt_q + LEN_ONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Completion bookkeeping follows the tlast handshake on the output.
  always_comb begin
    burst_done_d  = out_hs_last;
    burst_count_d = burst_count_q;
    if (out_hs_last) begin
      burst_count_d = burst_count_q + 32'd1;
    end
  end

  // Register the completion pulse and counter so both change on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      burst_done_q  <= 1'b0;
      burst_count_q <= '0;
    end else begin
      burst_done_q  <= burst_done_d;
      burst_count_q <= burst_count_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign burst_done  = burst_done_q;
  assign burst_count = burst_count_q;

endmodule

// File: tb/tb_beam_burst_framer.sv
// Self-checking bench for beam_burst_framer: a scoreboard queue holds the
// expected {data, last} of every accepted input beat and is popped on output.
module tb_beam_burst_framer;

  localparam int DW = 32;
  localparam int LW = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_enable;
  logic [LW-1:0] cfg_burst_len;
  logic [LW-1:0] cfg_gap_len;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic          busy;
  logic          burst_done;
  logic [31:0]   burst_count;

  always #5 clk = ~clk;

  beam_burst_framer #(.DWIDTH(DW), .LWIDTH(LW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cfg_enable          (cfg_enable),
    .cfg_burst_len       (cfg_burst_len),
    .cfg_gap_len         (cfg_gap_len),
    .axis_S_sample_tdata (s_tdata),
    .axis_S_sample_tvalid(s_tvalid),
    .axis_S_sample_tready(s_tready),
    .axis_M_burst_tdata  (m_tdata),
    .axis_M_burst_tvalid (m_tvalid),
    .axis_M_burst_tready (m_tready),
    .axis_M_burst_tlast  (m_tlast),
    .busy                (busy),
    .burst_done          (burst_done),
    .burst_count         (burst_count)
  );

  beat_t         sbQ[$];
  int            checks = 0;
  int            passes = 0;
  int            modelLen, modelBeat, accCnt, popCnt;
  logic [DW-1:0] srcData;
  logic          inHs, outHs, frontOk, frontLast;
  logic [DW-1:0] frontData;
  logic          obsTready, obsValid, obsLast, obsBusy, obsDone;
  logic [DW-1:0] obsData;
  logic [31:0]   obsCount;

  // Sample one cycle 1 ns after the falling edge, update the scoreboard, then advance.
  task automatic tick();
    beat_t nb;
    beat_t fb;
    #1;
    obsTready = s_tready;
    obsValid  = m_tvalid;
    obsData   = m_tdata;
    obsLast   = m_tlast;
    obsBusy   = busy;
    obsDone   = burst_done;
    obsCount  = burst_count;
    inHs      = s_tvalid && s_tready;
    outHs     = m_tvalid && m_tready;
    frontOk   = (sbQ.size() > 0);
    frontData = '0;
    frontLast = 1'b0;
    if (frontOk) begin
      fb        = sbQ[0];
      frontData = fb.data;
      frontLast = fb.last;
    end
    if (outHs && frontOk) begin
      fb = sbQ.pop_front();
      popCnt++;
    end
    if (inHs) begin
      nb.data   = s_tdata;
      nb.last   = (modelBeat == modelLen - 1);
      sbQ.push_back(nb);
      modelBeat = nb.last ? 0 : modelBeat + 1;
      accCnt++;
    end
    @(negedge clk);
    if (inHs) begin
      srcData++;
      s_tdata = srcData;
    end
  endtask

  task automatic resetDut();
    rst_n      = 1'b0;
    cfg_enable = 1'b0;
    s_tvalid   = 1'b0;
    m_tready   = 1'b0;
    tick();
    tick();
    rst_n     = 1'b1;
    sbQ.delete();
    modelBeat = 0;
    accCnt    = 0;
    popCnt    = 0;
    srcData   = 32'd1;
    s_tdata   = srcData;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_enable = 1'b1; cfg_burst_len = 16'd4; cfg_gap_len = 16'd0;
    s_tvalid = 1'b1; m_tready = 1'b1; modelLen = 4; modelBeat = 0; srcData = 32'd1; s_tdata = srcData;
    tick();
    checks++; if (obsTready !== 1'b0) $display("[TB] FAIL reset_tready_first: got %b want 0", obsTready); else passes++;
    tick();
    checks++; if (obsTready !== 1'b0) $display("[TB] FAIL reset_tready: got %b want 0", obsTready); else passes++;
    checks++; if (obsValid !== 1'b0) $display("[TB] FAIL reset_tvalid: got %b want 0", obsValid); else passes++;
    checks++; if (obsLast !== 1'b0) $display("[TB] FAIL reset_tlast: got %b want 0", obsLast); else passes++;
    checks++; if (obsData !== 32'd0) $display("[TB] FAIL reset_tdata: got %0h want 0", obsData); else passes++;
    checks++; if (obsBusy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", obsBusy); else passes++;
    checks++; if (obsDone !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", obsDone); else passes++;
    checks++; if (obsCount !== 32'd0) $display("[TB] FAIL reset_count: got %0d want 0", obsCount); else passes++;
  endtask

  // Two 4-beat bursts with no gap; one idle tready-low cycle after the first tlast.
  task automatic test_len4_gap0();
    int cyc = 0, lowCnt = 0, idleCnt = 0, doneCnt = 0;
    bit armed = 0, measured = 0;
    resetDut();
    modelLen = 4; cfg_burst_len = 16'd4; cfg_gap_len = 16'd0;
    s_tvalid = 1'b1; m_tready = 1'b1; cfg_enable = 1'b1;
    while (popCnt < 8 && cyc < 200) begin
      tick(); cyc++;
      if (obsDone) doneCnt++;
      if (outHs) begin
        checks++;
        if (!frontOk || obsData !== frontData || obsLast !== frontLast)
          $display("[TB] FAIL len4_beat: got %0h/%b want %0h/%b", obsData, obsLast, frontData, frontLast);
        else passes++;
      end
      if (accCnt >= 5) cfg_enable = 1'b0;
      if (armed) begin
        if (obsTready) begin armed = 0; measured = 1; end
        else begin lowCnt++; if (!obsBusy) idleCnt++; end
      end
      if (outHs && frontLast && !measured) armed = 1;
    end
    repeat (5) begin tick(); if (obsDone) doneCnt++; end
    checks++; if (popCnt !== 8) $display("[TB] FAIL len4_beats_out: got %0d want 8", popCnt); else passes++;
    checks++; if (lowCnt !== 1) $display("[TB] FAIL len4_low_cycles: got %0d want 1", lowCnt); else passes++;
    checks++; if (idleCnt !== 1) $display("[TB] FAIL len4_idle_cycles: got %0d want 1", idleCnt); else passes++;
    checks++; if (obsCount !== 32'd2) $display("[TB] FAIL len4_count: got %0d want 2", obsCount); else passes++;
    checks++; if (doneCnt !== 2) $display("[TB] FAIL len4_done_pulses: got %0d want 2", doneCnt); else passes++;
    checks++; if (accCnt !== 8) $display("[TB] FAIL len4_accepted: got %0d want 8", accCnt); else passes++;
  endtask

  // Three-beat bursts with a 5-cycle gap: 5 GAP plus 1 IDLE cycle after tlast.
  task automatic test_gap5();
    int cyc = 0, lowCnt = 0, idleCnt = 0;
    bit armed = 0, measured = 0;
    resetDut();
    modelLen = 3; cfg_burst_len = 16'd3; cfg_gap_len = 16'd5;
    s_tvalid = 1'b1; m_tready = 1'b1; cfg_enable = 1'b1;
    while (popCnt < 6 && cyc < 200) begin
      tick(); cyc++;
      if (outHs) begin
        checks++;
        if (!frontOk || obsData !== frontData || obsLast !== frontLast)
          $display("[TB] FAIL gap5_beat: got %0h/%b want %0h/%b", obsData, obsLast, frontData, frontLast);
        else passes++;
      end
      if (accCnt >= 4) cfg_enable = 1'b0;
      if (armed) begin
        if (obsTready) begin armed = 0; measured = 1; end
        else begin lowCnt++; if (!obsBusy) idleCnt++; end
      end
      if (outHs && frontLast && !measured) armed = 1;
    end
    repeat (4) tick();
    checks++; if (popCnt !== 6) $display("[TB] FAIL gap5_beats_out: got %0d want 6", popCnt); else passes++;
    checks++; if (lowCnt !== 6) $display("[TB] FAIL gap5_low_cycles: got %0d want 6", lowCnt); else passes++;
    checks++; if (idleCnt !== 1) $display("[TB] FAIL gap5_idle_cycles: got %0d want 1", idleCnt); else passes++;
    checks++; if (obsCount !== 32'd2) $display("[TB] FAIL gap5_count: got %0d want 2", obsCount); else passes++;
  endtask

  // Random sink backpressure: every valid output cycle must show the queue head.
  task automatic test_stall();
    int cyc = 0;
    resetDut();
    modelLen = 8; cfg_burst_len = 16'd8; cfg_gap_len = 16'd1;
    s_tvalid = 1'b1; cfg_enable = 1'b1;
    while (popCnt < 24 && cyc < 1000) begin
      m_tready = 1'($urandom_range(0, 1));
      tick(); cyc++;
      if (obsValid) begin
        checks++;
        if (!frontOk || obsData !== frontData || obsLast !== frontLast)
          $display("[TB] FAIL stall_beat: got %0h/%b want %0h/%b", obsData, obsLast, frontData, frontLast);
        else passes++;
      end
      if (accCnt >= 17) cfg_enable = 1'b0;
    end
    m_tready = 1'b1;
    repeat (6) tick();
    checks++; if (popCnt !== 24) $display("[TB] FAIL stall_beats_out: got %0d want 24", popCnt); else passes++;
    checks++; if (accCnt !== 24) $display("[TB] FAIL stall_accepted: got %0d want 24", accCnt); else passes++;
    checks++; if (obsCount !== 32'd3) $display("[TB] FAIL stall_count: got %0d want 3", obsCount); else passes++;
  endtask

  // Enable dropped after beat 2: the burst still completes, then nothing more starts.
  task automatic test_enable_drop();
    int cyc = 0, readyHigh = 0;
    resetDut();
    modelLen = 8; cfg_burst_len = 16'd8; cfg_gap_len = 16'd2;
    s_tvalid = 1'b1; m_tready = 1'b1; cfg_enable = 1'b1;
    while (popCnt < 8 && cyc < 200) begin
      tick(); cyc++;
      if (outHs) begin
        checks++;
        if (!frontOk || obsData !== frontData || obsLast !== frontLast)
          $display("[TB] FAIL drop_beat: got %0h/%b want %0h/%b", obsData, obsLast, frontData, frontLast);
        else passes++;
      end
      if (accCnt >= 2) cfg_enable = 1'b0;
    end
    repeat (15) begin tick(); if (obsTready) readyHigh++; end
    checks++; if (popCnt !== 8) $display("[TB] FAIL drop_beats_out: got %0d want 8", popCnt); else passes++;
    checks++; if (readyHigh !== 0) $display("[TB] FAIL drop_extra_tready: got %0d want 0", readyHigh); else passes++;
    checks++; if (obsBusy !== 1'b0) $display("[TB] FAIL drop_busy: got %b want 0", obsBusy); else passes++;
    checks++; if (obsCount !== 32'd1) $display("[TB] FAIL drop_count: got %0d want 1", obsCount); else passes++;
  endtask

  // One-cycle reset after beat 3 of a 6-beat burst, then a fresh full burst.
  task automatic test_reset_mid();
    int cyc = 0;
    resetDut();
    modelLen = 6; cfg_burst_len = 16'd6; cfg_gap_len = 16'd0;
    s_tvalid = 1'b1; m_tready = 1'b1; cfg_enable = 1'b1;
    while (accCnt < 3 && cyc < 100) begin
      tick(); cyc++;
      if (outHs) begin
        checks++;
        if (!frontOk || obsData !== frontData || obsLast !== frontLast)
          $display("[TB] FAIL rstmid_pre_beat: got %0h/%b want %0h/%b", obsData, obsLast, frontData, frontLast);
        else passes++;
      end
    end
    checks++; if (accCnt !== 3) $display("[TB] FAIL rstmid_reach_beat3: got %0d want 3", accCnt); else passes++;
    rst_n = 1'b0; m_tready = 1'b0;
    tick();
    checks++; if (obsTready !== 1'b0) $display("[TB] FAIL rstmid_tready_in_reset: got %b want 0", obsTready); else passes++;
    rst_n = 1'b1; m_tready = 1'b1;
    sbQ.delete(); modelBeat = 0; accCnt = 0; popCnt = 0;
    #1;
    checks++;
    if ({m_tvalid, m_tlast, m_tdata, busy, burst_done, burst_count, s_tready} !== '0)
      $display("[TB] FAIL rstmid_outputs: got v=%b l=%b d=%0h busy=%b done=%b cnt=%0d rdy=%b want all 0",
               m_tvalid, m_tlast, m_tdata, busy, burst_done, burst_count, s_tready);
    else passes++;
    cyc = 0;
    while (popCnt < 6 && cyc < 100) begin
      tick(); cyc++;
      if (outHs) begin
        checks++;
        if (!frontOk || obsData !== frontData || obsLast !== frontLast)
          $display("[TB] FAIL rstmid_post_beat: got %0h/%b want %0h/%b", obsData, obsLast, frontData, frontLast);
        else passes++;
      end
      if (accCnt >= 6) cfg_enable = 1'b0;
    end
    repeat (4) tick();
    checks++; if (popCnt !== 6) $display("[TB] FAIL rstmid_beats_out: got %0d want 6", popCnt); else passes++;
    checks++; if (obsCount !== 32'd1) $display("[TB] FAIL rstmid_count: got %0d want 1", obsCount); else passes++;
  endtask

  // Length 0 never starts a burst; length 1 makes every beat a tlast with a done pulse.
  task automatic test_len0_len1();
    int cyc = 0, readyHigh = 0, busyHigh = 0;
    logic prevLastHs = 1'b0;
    resetDut();
    cfg_burst_len = 16'd0; cfg_gap_len = 16'd0;
    s_tvalid = 1'b1; m_tready = 1'b1; cfg_enable = 1'b1;
    repeat (10) begin tick(); if (obsTready) readyHigh++; if (obsBusy) busyHigh++; end
    checks++; if (readyHigh !== 0) $display("[TB] FAIL len0_tready: got %0d want 0", readyHigh); else passes++;
    checks++; if (busyHigh !== 0) $display("[TB] FAIL len0_busy: got %0d want 0", busyHigh); else passes++;
    modelLen = 1; cfg_burst_len = 16'd1;
    while ((popCnt < 4 || cyc < 20) && cyc < 200) begin
      tick(); cyc++;
      checks++;
      if (obsDone !== prevLastHs) $display("[TB] FAIL len1_done_pulse: got %b want %b", obsDone, prevLastHs);
      else passes++;
      prevLastHs = outHs && frontLast;
      if (outHs) begin
        checks++;
        if (!frontOk || obsData !== frontData || obsLast !== 1'b1)
          $display("[TB] FAIL len1_beat: got %0h/%b want %0h/1", obsData, obsLast, frontData);
        else passes++;
      end
      if (accCnt >= 4) cfg_enable = 1'b0;
    end
    checks++; if (popCnt !== 4) $display("[TB] FAIL len1_beats_out: got %0d want 4", popCnt); else passes++;
    checks++; if (obsCount !== 32'd4) $display("[TB] FAIL len1_count: got %0d want 4", obsCount); else passes++;
  endtask

  initial begin
    rst_n = 1'b0; cfg_enable = 1'b0; cfg_burst_len = '0; cfg_gap_len = '0;
    s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;
    modelLen = 1; modelBeat = 0; accCnt = 0; popCnt = 0; srcData = 32'd1;
    test_reset();
    test_len4_gap0();
    test_gap5();
    test_stall();
    test_enable_drop();
    test_reset_mid();
    test_len0_len1();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
